// File: rtl/dpram_banked_init.sv
// Banked single-clock true dual-port RAM with post-reset zero sweep, read-valid strobes and A-wins write collisions.
// Define DPRAM_BANKED_BYPASS_EN to forward same-cycle cross-port writes to the reader (write-first); default is read-first.
module dpram_banked_init #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4096,
    parameter int BankDepth = 1024,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    output logic                   init_done_o,
    input  logic [AddrWidth-1:0]   a_addr_i,
    input  logic [DataWidth-1:0]   a_din_i,
    input  logic [DataWidth/8-1:0] a_be_i,
    input  logic                   a_wren_i,
    input  logic                   a_rden_i,
    output logic [DataWidth-1:0]   a_dout_o,
    output logic                   a_rvalid_o,
    input  logic [AddrWidth-1:0]   b_addr_i,
    input  logic [DataWidth-1:0]   b_din_i,
    input  logic [DataWidth/8-1:0] b_be_i,
    input  logic                   b_wren_i,
    input  logic                   b_rden_i,
    output logic [DataWidth-1:0]   b_dout_o,
    output logic                   b_rvalid_o
);

    localparam int NbBanks  = Depth / BankDepth;
    localparam int RowWidth = $clog2(BankDepth);
    localparam int BankSelW = (NbBanks > 1) ? $clog2(NbBanks) : 1;
    localparam int NbBytes  = DataWidth / 8;

    if (Depth % BankDepth != 0) begin : g_chk_depth
        $fatal(1, "Depth must be a multiple of BankDepth");
    end
    if ((BankDepth & (BankDepth - 1)) != 0) begin : g_chk_bank
        $fatal(1, "BankDepth must be a power of two");
    end
    if ((DataWidth % 8 != 0) || (DataWidth < 8) || (DataWidth > 128)) begin : g_chk_width
        $fatal(1, "DataWidth must be a multiple of 8 in 8..128");
    end

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e                state_q;
    logic [RowWidth-1:0]   sweep_q;
    logic                  done_q;

    logic [DataWidth-1:0]  mem       [NbBanks][BankDepth];
    logic [DataWidth-1:0]  a_rd_bank [NbBanks];
    logic [DataWidth-1:0]  b_rd_bank [NbBanks];

    logic [BankSelW-1:0]   a_bank, b_bank, a_bank_q, b_bank_q;
    logic [RowWidth-1:0]   a_row, b_row;
    logic                  ready, a_wr, b_wr, a_rd, b_rd;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [DataWidth-1:0]  a_hold_q, b_hold_q, a_merged, b_merged;

    assign a_bank = BankSelW'(a_addr_i >> RowWidth);
    assign b_bank = BankSelW'(b_addr_i >> RowWidth);
    assign a_row  = a_addr_i[RowWidth-1:0];
    assign b_row  = b_addr_i[RowWidth-1:0];

    // Requests are dropped outright during the sweep; a write on a port suppresses its own read.
    assign ready = (state_q == ST_READY);
    assign a_wr  = ready && a_wren_i;
    assign b_wr  = ready && b_wren_i;
    assign a_rd  = ready && a_rden_i && !a_wren_i;
    assign b_rd  = ready && b_rden_i && !b_wren_i;

    // NOTE: the array is deliberately left out of reset; the zero sweep clears it instead,
    // which keeps it mappable onto RAM macros that have no reset pin.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            for (int bk = 0; bk < NbBanks; bk++) begin
                mem[bk][sweep_q] <= '0;
            end
        end else begin
            for (int i = 0; i < NbBytes; i++) begin
                if (b_wr && b_be_i[i]) mem[b_bank][b_row][8*i +: 8] <= b_din_i[8*i +: 8];
            end
            // A's byte writes are scheduled after B's, so A wins where both enable the same byte.
            for (int i = 0; i < NbBytes; i++) begin
                if (a_wr && a_be_i[i]) mem[a_bank][a_row][8*i +: 8] <= a_din_i[8*i +: 8];
            end
            // NOTE: non-blocking writes mean these reads see the pre-write word (read-first).
            if (a_rd) a_rd_bank[a_bank] <= mem[a_bank][a_row];
            if (b_rd) b_rd_bank[b_bank] <= mem[b_bank][b_row];
        end
    end

`ifdef DPRAM_BANKED_BYPASS_EN
    logic [NbBytes-1:0]   a_fwd_be_q, b_fwd_be_q;
    logic [DataWidth-1:0] a_fwd_data_q, b_fwd_data_q;

    function automatic logic [DataWidth-1:0] merge_bytes(input logic [DataWidth-1:0] raw,
                                                         input logic [NbBytes-1:0]   be,
                                                         input logic [DataWidth-1:0] fwd);
        logic [DataWidth-1:0] res;
        res = raw;
        for (int i = 0; i < NbBytes; i++) begin
            if (be[i]) res[8*i +: 8] = fwd[8*i +: 8];
        end
        return res;
    endfunction

    assign a_merged = merge_bytes(a_rd_bank[a_bank_q], a_fwd_be_q, a_fwd_data_q);
    assign b_merged = merge_bytes(b_rd_bank[b_bank_q], b_fwd_be_q, b_fwd_data_q);
`else
    assign a_merged = a_rd_bank[a_bank_q];
    assign b_merged = b_rd_bank[b_bank_q];
`endif

    assign a_dout_o    = a_rvalid_q ? a_merged : a_hold_q;
    assign b_dout_o    = b_rvalid_q ? b_merged : b_hold_q;
    assign a_rvalid_o  = a_rvalid_q;
    assign b_rvalid_o  = b_rvalid_q;
    assign init_done_o = done_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            done_q     <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_bank_q   <= '0;
            b_bank_q   <= '0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
`ifdef DPRAM_BANKED_BYPASS_EN
            a_fwd_be_q   <= '0;
            b_fwd_be_q   <= '0;
            a_fwd_data_q <= '0;
            b_fwd_data_q <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == RowWidth'(BankDepth - 1)) begin
                        state_q <= ST_READY;
                        done_q  <= 1'b1;
                    end
                end
                ST_READY: state_q <= ST_READY;
            endcase

            a_rvalid_q <= a_rd;
            b_rvalid_q <= b_rd;
            if (a_rd) a_bank_q <= a_bank;
            if (b_rd) b_bank_q <= b_bank;
            if (a_rvalid_q) a_hold_q <= a_merged;
            if (b_rvalid_q) b_hold_q <= b_merged;
`ifdef DPRAM_BANKED_BYPASS_EN
            // Only the other port can be writing a word this port reads; a self-write drops the read.
            if (a_rd) begin
                a_fwd_be_q   <= (b_wr && b_addr_i == a_addr_i) ? b_be_i : '0;
                a_fwd_data_q <= b_din_i;
            end
            if (b_rd) begin
                b_fwd_be_q   <= (a_wr && a_addr_i == b_addr_i) ? a_be_i : '0;
                b_fwd_data_q <= a_din_i;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dpram_banked_init.sv
// Self-checking bench for dpram_banked_init: directed spec cases plus random dual-port traffic against a word-array model.
// Honours DPRAM_BANKED_BYPASS_EN when computing expected cross-port read data.
module tb_dpram_banked_init;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DEPTH = 4096;
    localparam int BANK_DEPTH = 1024;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          init_done_o;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din, a_dout, b_dout;
    logic [3:0]    a_be, b_be;
    logic          a_wren, a_rden, b_wren, b_rden, a_rvalid, b_rvalid;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_a, last_b;

    always #5 clk_i = ~clk_i;

    dpram_banked_init #(.DataWidth(DW), .Depth(DEPTH), .BankDepth(BANK_DEPTH)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .init_done_o(init_done_o),
        .a_addr_i(a_addr), .a_din_i(a_din), .a_be_i(a_be), .a_wren_i(a_wren), .a_rden_i(a_rden),
        .a_dout_o(a_dout), .a_rvalid_o(a_rvalid),
        .b_addr_i(b_addr), .b_din_i(b_din), .b_be_i(b_be), .b_wren_i(b_wren), .b_rden_i(b_rden),
        .b_dout_o(b_dout), .b_rvalid_o(b_rvalid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_wren = 0; a_rden = 0; b_wren = 0; b_rden = 0;
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0; a_be = '0; b_be = '0;
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_a = '0;
        last_b = '0;
    endtask

    // Word content after this cycle's writes: per byte, A's enabled byte, else B's, else the stored byte.
    function automatic logic [DW-1:0] post_word(input logic [AW-1:0] addr);
        logic [DW-1:0] w;
        w = model[addr];
        for (int i = 0; i < 4; i++) begin
            if (a_wren && a_addr == addr && a_be[i]) w[8*i +: 8] = a_din[8*i +: 8];
            else if (b_wren && b_addr == addr && b_be[i]) w[8*i +: 8] = b_din[8*i +: 8];
        end
        return w;
    endfunction

    task automatic do_cycle(input logic aw, input logic ar, input logic [AW-1:0] aa,
                            input logic [DW-1:0] ad, input logic [3:0] abe,
                            input logic bw, input logic br, input logic [AW-1:0] ba,
                            input logic [DW-1:0] bd, input logic [3:0] bbe);
        logic          exp_av, exp_bv;
        logic [DW-1:0] exp_ad, exp_bd, new_a, new_b;
        a_wren = aw; a_rden = ar; a_addr = aa; a_din = ad; a_be = abe;
        b_wren = bw; b_rden = br; b_addr = ba; b_din = bd; b_be = bbe;
        exp_av = ar && !aw;
        exp_bv = br && !bw;
`ifdef DPRAM_BANKED_BYPASS_EN
        exp_ad = post_word(aa);
        exp_bd = post_word(ba);
`else
        exp_ad = model[aa];
        exp_bd = model[ba];
`endif
        new_a = post_word(aa);
        new_b = post_word(ba);
        @(posedge clk_i);
        #1;
        if (aw) model[aa] = new_a;
        if (bw) model[ba] = new_b;
        if (exp_av) last_a = exp_ad;
        if (exp_bv) last_b = exp_bd;
        check("a_rvalid", a_rvalid, exp_av);
        check("a_dout", a_dout, last_a);
        check("b_rvalid", b_rvalid, exp_bv);
        check("b_dout", b_dout, last_b);
        idle();
    endtask

    task automatic apply_reset();
        rstn_i = 1'b0;
        idle();
        #2;
        check("rst_done", init_done_o, 1'b0);
        check("rst_a_rvalid", a_rvalid, 1'b0);
        check("rst_b_rvalid", b_rvalid, 1'b0);
        check("rst_a_dout", a_dout, 32'h0);
        check("rst_b_dout", b_dout, 32'h0);
        zero_model();
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    // Counts edges from reset release; a write and read at cycle 10 must be dropped.
    task automatic sweep_check();
        for (int c = 1; c <= BANK_DEPTH; c++) begin
            if (c == 10) begin
                a_wren = 1; a_addr = 12'h123; a_din = 32'hFFFF_FFFF; a_be = 4'hF;
                b_rden = 1; b_addr = 12'h123;
            end
            @(posedge clk_i);
            #1;
            if (c == 10) begin
                check("sweep_drop_rvalid", b_rvalid, 1'b0);
                idle();
            end
            if (c == BANK_DEPTH - 1) check("done_early", init_done_o, 1'b0);
        end
        check("done_rise", init_done_o, 1'b1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'(($urandom_range(0, 3) << 10) | $urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        apply_reset();
        sweep_check();

        for (int i = 0; i < DEPTH; i += 2) begin
            do_cycle(0, 1, AW'(i), '0, '0, 0, 1, AW'(i + 1), '0, '0);
        end

        do_cycle(1, 0, 12'h403, 32'hDEAD_BEEF, 4'hF, 0, 0, '0, '0, '0);
        do_cycle(0, 1, 12'h403, '0, '0, 0, 0, '0, '0, '0);
        check("deadbeef_rvalid", a_rvalid, 1'b1);
        check("deadbeef_dout", a_dout, 32'hDEAD_BEEF);
        do_cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        check("deadbeef_pulse", a_rvalid, 1'b0);

        do_cycle(1, 0, 12'h010, 32'h1122_3344, 4'b0011, 1, 0, 12'h010, 32'hAABB_CCDD, 4'b0110);
        do_cycle(0, 1, 12'h010, '0, '0, 0, 0, '0, '0, '0);
        check("collide_merge", a_dout, 32'h00BB_3344);

        do_cycle(0, 0, '0, '0, '0, 1, 0, 12'hC00, 32'h1234_5678, 4'hF);
        do_cycle(1, 0, 12'hC00, 32'hCAFE_F00D, 4'hF, 0, 1, 12'hC00, '0, '0);
`ifdef DPRAM_BANKED_BYPASS_EN
        check("cross_read", b_dout, 32'hCAFE_F00D);
`else
        check("cross_read", b_dout, 32'h1234_5678);
`endif

        do_cycle(1, 0, 12'h005, 32'h1, 4'hF, 1, 0, 12'hC05, 32'h2, 4'hF);
        do_cycle(0, 1, 12'h005, '0, '0, 0, 1, 12'hC05, '0, '0);
        check("bank0_row5", a_dout, 32'h1);
        check("bank3_row5", b_dout, 32'h2);

        for (int n = 0; n < 3000; n++) begin
            do_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom(),
                     4'($urandom()),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom(),
                     4'($urandom()));
        end

        // Read accepted, then reset lands before the next edge: strobe and data must clear.
        a_rden = 1; a_addr = 12'h403;
        @(posedge clk_i);
        #1;
        check("inflight_rvalid", a_rvalid, 1'b1);
        apply_reset();
        repeat (500) @(posedge clk_i);
        #1;
        check("mid_sweep_done", init_done_o, 1'b0);
        apply_reset();
        sweep_check();
        do_cycle(0, 1, 12'h123, '0, '0, 0, 1, 12'h403, '0, '0);
        check("dropped_write", a_dout, 32'h0);
        check("resweep_zero", b_dout, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
